// File: rtl/mtr_drv_gen2.sv
// Purpose: N-phase half-bridge gate driver with a shared PWM, per-phase dead time and latched fault shutdown.
// Latency: gates follow the registered PWM one cycle later plus DEAD_CYC cycles on every request change; fault blanks gates one cycle after flt.
// Backpressure: none; free-running, inputs are sampled every cycle.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   duty      in   PWM_W   requested duty, moved into the shadow register at period wrap
//   sel       in   2*NUM_PH per-phase mode, phase i = sel[2i+1:2i] (00 coast, 01 inv, 10 fwd, 11 brake)
//   en        in   0 forces every phase to coast
//   flt       in   fault request, active high
//   flt_clr   in   clears the latched fault when flt is low
//   high/low  out  NUM_PH  high/low-side gate per phase
//   pwm_sync  out  1-cycle pulse on the first cycle of each PWM period
//   flt_lat   out  latched fault status
`timescale 1ns/1ps
module mtr_drv_gen2 #(
  parameter int PWM_W    = 11,
  parameter int NUM_PH   = 3,
  parameter int DEAD_CYC = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PWM_W-1:0]      duty,
  input  logic [2*NUM_PH-1:0]   sel,
  input  logic                  en,
  input  logic                  flt,
  input  logic                  flt_clr,
  output logic [NUM_PH-1:0]     high,
  output logic [NUM_PH-1:0]     low,
  output logic                  pwm_sync,
  output logic                  flt_lat
);

  localparam int               DCW     = $clog2(DEAD_CYC + 1);
  localparam logic [PWM_W-1:0] CNT_MAX = '1;
  localparam logic [DCW-1:0]   DC_LOAD = DCW'(DEAD_CYC);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty_sh;
  logic             r_pwm;
  logic             r_sync;
  logic             r_flt_lat;
  logic [PWM_W-1:0] w_cnt_next;
  logic [PWM_W-1:0] w_duty_sh_next;

  assign w_cnt_next     = r_cnt + PWM_W'(1);
  // The shadow only takes a new duty on the last cycle of a period, so a
  // duty write can never cut a running period short or stretch it.
  assign w_duty_sh_next = (r_cnt == CNT_MAX) ? duty : r_duty_sh;

  // pwm and pwm_sync are computed from next-state values so that, once
  // registered, they line up with the cycle in which r_cnt holds that count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_duty_sh <= '0;
      r_pwm     <= 1'b0;
      r_sync    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_duty_sh <= w_duty_sh_next;
      r_pwm     <= (w_cnt_next < w_duty_sh_next);
      r_sync    <= (w_cnt_next == '0);
    end
  end

  // Fault has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt_lat <= 1'b0;
    end else if (flt) begin
      r_flt_lat <= 1'b1;
    end else if (flt_clr) begin
      r_flt_lat <= 1'b0;
    end
  end

  assign pwm_sync = r_sync;
  assign flt_lat  = r_flt_lat;

  for (genvar g = 0; g < NUM_PH; g++) begin : g_ph
    logic [1:0]     w_mode;
    logic           w_hi_rq;
    logic           w_lo_rq;
    logic           w_gate_ok;
    logic           r_hi_q;
    logic           r_lo_q;
    logic [DCW-1:0] r_dc;

    assign w_mode = (en && !r_flt_lat) ? sel[2*g+1:2*g] : 2'b00;

    always_comb begin
      w_hi_rq = 1'b0;
      w_lo_rq = 1'b0;
      case (w_mode)
        2'b01:   begin w_hi_rq = ~r_pwm; w_lo_rq = r_pwm;  end
        2'b10:   begin w_hi_rq = r_pwm;  w_lo_rq = ~r_pwm; end
        2'b11:   begin w_lo_rq = r_pwm;                    end
        default: begin                                     end
      endcase
    end

    // Any change of request (including towards off) restarts the full dead
    // time; the copy tracks the request immediately, the gates wait for dc.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hi_q <= 1'b0;
        r_lo_q <= 1'b0;
        r_dc   <= '0;
      end else if ({w_hi_rq, w_lo_rq} != {r_hi_q, r_lo_q}) begin
        r_hi_q <= w_hi_rq;
        r_lo_q <= w_lo_rq;
        r_dc   <= DC_LOAD;
      end else if (r_dc != '0) begin
        r_dc   <= r_dc - DCW'(1);
      end
    end

    // The latched fault blanks the gates directly so shutdown does not wait
    // for the dead-time counter; a shoot-through pair is never passed on.
    assign w_gate_ok = (r_dc == '0) && !r_flt_lat && !(r_hi_q && r_lo_q);
    assign high[g]   = r_hi_q & w_gate_ok;
    assign low[g]    = r_lo_q & w_gate_ok;
  end

endmodule

// File: tb/tb_mtr_drv_gen2.sv
`timescale 1ns/1ps
module tb_mtr_drv_gen2;

  typedef struct packed {
    logic [2:0][11:0] hi;
    logic [2:0][11:0] lo;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic [5:0]  sel;
    logic [10:0] duty;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] duty;
  logic [5:0]  sel;
  logic        en, flt, flt_clr;
  logic [2:0]  high, low;
  logic        pwm_sync, flt_lat;

  logic        rst5_n;
  logic [3:0]  duty5;
  logic [9:0]  sel5;
  logic        en5, flt5, flt_clr5;
  logic [4:0]  high5, low5;
  logic        sync5, flt_lat5;

  int checks = 0;
  int passed = 0;
  int ovl_main = 0;
  int ovl5 = 0;

  always #5 clk = ~clk;

  mtr_drv_gen2 #(.PWM_W(11), .NUM_PH(3), .DEAD_CYC(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .duty(duty), .sel(sel), .en(en), .flt(flt),
    .flt_clr(flt_clr), .high(high), .low(low), .pwm_sync(pwm_sync), .flt_lat(flt_lat)
  );

  mtr_drv_gen2 #(.PWM_W(4), .NUM_PH(5), .DEAD_CYC(1)) u_dut5 (
    .clk(clk), .rst_n(rst5_n), .duty(duty5), .sel(sel5), .en(en5), .flt(flt5),
    .flt_clr(flt_clr5), .high(high5), .low(low5), .pwm_sync(sync5), .flt_lat(flt_lat5)
  );

  always @(negedge clk) begin
    if ((high & low) != 3'b000) ovl_main++;
    if ((high5 & low5) != 5'b00000) ovl5++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_ge(input string name, input int act, input int lim);
    checks++;
    if (act >= lim) passed++;
    else $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
  endtask

  task automatic wait_sync();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_sync && n < 2100);
    if (!pwm_sync) chk("sync_timeout", 0, 1);
  endtask

  // Counts gate-on cycles over one period, starting with the current sample.
  task automatic measure(output logic [2:0][11:0] hc, output logic [2:0][11:0] lc, output int sc);
    hc = '0; lc = '0; sc = 0;
    for (int c = 0; c < 2048; c++) begin
      if (c > 0) @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        hc[p] += 12'(high[p]);
        lc[p] += 12'(low[p]);
      end
      sc += int'(pwm_sync);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic [5:0] s, input logic [10:0] d,
                              input int h2, input int h1, input int h0,
                              input int l2, input int l1, input int l0);
    vec_t v;
    v.en = e; v.sel = s; v.duty = d;
    v.exp.hi[2] = 12'(h2); v.exp.hi[1] = 12'(h1); v.exp.hi[0] = 12'(h0);
    v.exp.lo[2] = 12'(l2); v.exp.lo[1] = 12'(l1); v.exp.lo[0] = 12'(l0);
    return v;
  endfunction

  vec_t             vecs [7];
  exp_t             sb_q [$];
  exp_t             e;
  logic [2:0][11:0] hc, lc;
  int               sc;

  initial begin
    // Per-period gate-on counts: every pwm edge costs 32 cycles of dead time.
    vecs[0] = mk(1'b1, 6'b10_10_10, 11'd1024,  992,  992,  992,  992,  992,  992);
    vecs[1] = mk(1'b1, 6'b11_01_10, 11'd200,     0, 1816,  168,  168,  168, 1816);
    vecs[2] = mk(1'b1, 6'b00_10_01, 11'd1500,    0, 1468,  516,    0,  516, 1468);
    vecs[3] = mk(1'b1, 6'b10_10_10, 11'd0,       0,    0,    0, 2048, 2048, 2048);
    vecs[4] = mk(1'b1, 6'b10_10_10, 11'd2047, 2015, 2015, 2015,    0,    0,    0);
    vecs[5] = mk(1'b1, 6'b01_01_01, 11'd2047,    0,    0,    0, 2015, 2015, 2015);
    vecs[6] = mk(1'b0, 6'b10_10_10, 11'd1024,    0,    0,    0,    0,    0,    0);

    rst_n = 1'b0; rst5_n = 1'b0;
    duty = 11'd1024; sel = 6'b10_10_10; en = 1'b1; flt = 1'b0; flt_clr = 1'b0;
    duty5 = 4'd8; sel5 = 10'b10_10_10_10_10; en5 = 1'b1; flt5 = 1'b0; flt_clr5 = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_high", int'(high), 0);
    chk("rst_low", int'(low), 0);
    chk("rst_sync", int'(pwm_sync), 0);
    chk("rst_flt_lat", int'(flt_lat), 0);
    rst_n = 1'b1; rst5_n = 1'b1;

    // Table vectors through the scoreboard queue.
    for (int i = 0; i < 7; i++) begin
      wait_sync();
      en = vecs[i].en; sel = vecs[i].sel; duty = vecs[i].duty;
      sb_q.push_back(vecs[i].exp);
      wait_sync();
      wait_sync();
      measure(hc, lc, sc);
      e = sb_q.pop_front();
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("v%0d_hi%0d", i, p), int'(hc[p]), int'(e.hi[p]));
        chk($sformatf("v%0d_lo%0d", i, p), int'(lc[p]), int'(e.lo[p]));
      end
      chk($sformatf("v%0d_sync", i), sc, 1);
    end

    // Duty change mid-period only takes effect from the next period.
    en = 1'b1; sel = 6'b10_10_10; duty = 11'd200;
    wait_sync(); wait_sync(); wait_sync();
    hc = '0; lc = '0;
    for (int c = 0; c < 2048; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 500) duty = 11'd1500;
      hc[0] += 12'(high[0]);
      lc[0] += 12'(low[0]);
    end
    chk("t2_cur_hi", int'(hc[0]), 168);
    chk("t2_cur_lo", int'(lc[0]), 1816);
    @(negedge clk);
    chk("t2_sync", int'(pwm_sync), 1);
    measure(hc, lc, sc);
    chk("t2_next_hi", int'(hc[0]), 1468);
    chk("t2_next_lo", int'(lc[0]), 516);

    // Mode change 10 -> 01 on phase 0 while pwm is high.
    duty = 11'd1024;
    wait_sync(); wait_sync(); wait_sync();
    repeat (600) @(negedge clk);
    chk("t3_pre_hi", int'(high[0]), 1);
    sel[1:0] = 2'b01;
    begin
      int z = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (high[0] || low[0]) break;
        z++;
      end
      chk("t3_dead", z, 32);
    end
    chk("t3_after", int'({high[0], low[0]}), 1);
    chk("t3_ph1_hi", int'(high[1]), 1);

    // One-cycle fault pulse, hold, clear, re-arm after dead time.
    sel = 6'b10_10_10;
    wait_sync(); wait_sync();
    repeat (300) @(negedge clk);
    chk("t4_pre_hi", int'(high), 7);
    flt = 1'b1;
    @(negedge clk);
    flt = 1'b0;
    chk("t4_lat", int'(flt_lat), 1);
    chk("t4_hi", int'(high), 0);
    chk("t4_lo", int'(low), 0);
    begin
      int bad = 0;
      repeat (200) begin
        @(negedge clk);
        if (!flt_lat || (high | low) != 3'b000) bad++;
      end
      chk("t4_hold", bad, 0);
    end
    flt_clr = 1'b1;
    @(negedge clk);
    flt_clr = 1'b0;
    chk("t4_clr", int'(flt_lat), 0);
    begin
      int n = 0;
      while (n < 3000 && (high | low) == 3'b000) begin
        @(negedge clk);
        n++;
      end
      chk_ge("t4_rearm_dead", n, 32);
      chk("t4_rearm_seen", int'(n < 3000), 1);
    end

    // Fault and clear together: fault wins.
    flt = 1'b1; flt_clr = 1'b1;
    @(negedge clk);
    flt = 1'b0; flt_clr = 1'b0;
    chk("t5_both", int'(flt_lat), 1);
    flt_clr = 1'b1;
    @(negedge clk);
    flt_clr = 1'b0;
    chk("t5_clr", int'(flt_lat), 0);

    // Asynchronous reset mid-period, then restart from cnt=0.
    wait_sync(); wait_sync();
    repeat (300) @(negedge clk);
    chk("ar_pre_hi", int'(high), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_hi", int'(high), 0);
    chk("ar_lo", int'(low), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!pwm_sync && n < 2100);
      chk("ar_restart", n, 2048);
    end
    chk("ovl_main", ovl_main, 0);

    // Five-phase, one-cycle dead time: random stress.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      duty5    = 4'($urandom);
      sel5     = 10'($urandom);
      en5      = ($urandom_range(0, 15) != 0);
      flt5     = ($urandom_range(0, 63) == 0);
      flt_clr5 = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    en5 = 1'b1; flt5 = 1'b0; flt_clr5 = 1'b1; sel5 = 10'b10_10_10_10_10; duty5 = 4'd8;
    @(negedge clk);
    flt_clr5 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!sync5 && n < 40);
      if (!sync5) chk("t6_sync_timeout", 0, 1);
    end
    repeat (5) @(negedge clk);
    chk("t6_pre_hi", int'(high5), 31);
    #2 rst5_n = 1'b0;
    #1;
    chk("t6_ar_hi", int'(high5), 0);
    chk("t6_ar_lo", int'(low5), 0);
    @(negedge clk);
    rst5_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_ovl", ovl5, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
